// File: rtl/onehot_to_binary_decoder.sv
// Registered 16-bit one-hot to 4-bit binary decoder with valid/ready handshake and an
// illegal-code counter. Define ONEHOT_LSB_PRIORITY_EN to decode multi-hot codes to their lowest set bit.
module onehot_to_binary_decoder #(
  parameter int unsigned WID         = 4,
  parameter int unsigned ONEHOT_WID  = 16,
  parameter int unsigned ERR_CNT_WID = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ONEHOT_WID-1:0]  in_onehot,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WID-1:0]         out_bin,
  output logic                   out_err,
  output logic [ERR_CNT_WID-1:0] err_cnt
);

  if (ONEHOT_WID != 2 ** WID) begin : gen_bad_width
    $error("onehot_to_binary_decoder: ONEHOT_WID must equal 2**WID");
  end

  logic                   valid_q;
  logic [WID-1:0]         bin_q, bin_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_WID-1:0] cnt_q, cnt_d;

  logic           seen, multi;
  logic [WID-1:0] low_idx;
  logic [WID-1:0] dec_bin;
  logic           dec_err;
  logic           accept;

  // Scan from the top so the final assignment leaves the lowest set bit.
  always_comb begin
    seen    = 1'b0;
    multi   = 1'b0;
    low_idx = '0;
    for (int i = int'(ONEHOT_WID) - 1; i >= 0; i--) begin
      if (in_onehot[i]) begin
        if (seen) multi = 1'b1;
        seen    = 1'b1;
        low_idx = i[WID-1:0];
      end
    end
  end

  always_comb begin
    dec_err = !seen || multi;
`ifdef ONEHOT_LSB_PRIORITY_EN
    dec_bin = low_idx;
`else
    dec_bin = multi ? '0 : low_idx;
`endif
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    bin_d = bin_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (accept) begin
      bin_d = dec_bin;
      err_d = dec_err;
      if (dec_err && (cnt_q != {ERR_CNT_WID{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (in_ready) valid_q <= in_valid;
      bin_q <= bin_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_bin   = bin_q;
  assign out_err   = err_q;
  assign err_cnt   = cnt_q;

endmodule
